// File: rtl/in_shift_frame_reg.sv
// rtl/in_shift_frame_reg.sv - multi-channel serial-to-parallel frame register
// with bit-order select, continuous framing, valid/ack handoff and overrun flag.
module in_shift_frame_reg #(
  parameter int N1 = 102,
  parameter int N2 = 6,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(N1)
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   Start,
  input  logic                   Continuous,
  input  logic                   Stop,
  input  logic                   SelKeep,
  input  logic [N2-1:0]          In,
  output logic [N2-1:0][N1-1:0]  Out,
  output logic                   OutValid,
  input  logic                   OutAck,
  output logic                   Busy,
  output logic [CW-1:0]          BitCnt,
  output logic                   Overrun,
  input  logic                   ClrOvr
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [N2-1:0][N1-1:0]  sr, sr_nxt;
  logic                   shift_en, complete, deliver;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Stop beats Start, Start beats shifting/completion.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    complete  = 1'b0;
    if (Stop) begin
      state_nxt = IDLE;
    end else if (Start) begin
      state_nxt = SHIFT;
    end else if (state == SHIFT && !SelKeep) begin
      shift_en = 1'b1;
      if (BitCnt == CW'(N1 - 1)) begin
        complete = 1'b1;
        if (!Continuous) state_nxt = IDLE;
      end
    end
    deliver = complete && (!OutValid || OutAck);
    for (int c = 0; c < N2; c++) begin
      if (MSB_FIRST) sr_nxt[c] = {sr[c][N1-2:0], In[c]};
      else           sr_nxt[c] = {In[c], sr[c][N1-1:1]};
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sr       <= '0;
      BitCnt   <= '0;
      Out      <= '0;
      OutValid <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (Stop || Start) begin
        BitCnt <= '0;
      end else if (shift_en) begin
        sr     <= sr_nxt;
        BitCnt <= complete ? '0 : BitCnt + CW'(1);
      end

      // A completing frame takes the holding register in the same edge it is acked.
      if (deliver) begin
        Out      <= sr_nxt;
        OutValid <= 1'b1;
      end else if (OutValid && OutAck) begin
        OutValid <= 1'b0;
      end

      if (complete && OutValid && !OutAck) Overrun <= 1'b1;
      else if (ClrOvr)                     Overrun <= 1'b0;
    end
  end

  assign Busy = (state == SHIFT);

endmodule
